// File: rtl/axi4_reg_slave.sv
// axi4_reg_slave: AXI4 responder exposing a bank of NR_OF_REGS_P read/write
// registers. Single-beat writes with byte strobes, incrementing read bursts.
// Register contents are driven out flat on reg_out.
// Optional macro AXI4_REG_SLAVE_DECERR_EN: out-of-range accesses answer
// DECERR (2'b11) instead of SLVERR (2'b10).
module axi4_reg_slave #(
    parameter int AXI4_ID_WIDTH_P   = 2,
    parameter int AXI4_ADDR_WIDTH_P = 16,
    parameter int AXI4_DATA_WIDTH_P = 32,
    parameter int AXI4_STRB_WIDTH_P = 4,
    parameter int NR_OF_REGS_P      = 8,
    parameter int RID_VALUE_P       = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [AXI4_ADDR_WIDTH_P-1:0]              awaddr,
    input  logic                                      awvalid,
    output logic                                      awready,
    input  logic [AXI4_DATA_WIDTH_P-1:0]              wdata,
    input  logic [AXI4_STRB_WIDTH_P-1:0]              wstrb,
    input  logic                                      wlast,
    input  logic                                      wvalid,
    output logic                                      wready,
    output logic [1:0]                                bresp,
    output logic                                      bvalid,
    input  logic                                      bready,
    input  logic [AXI4_ADDR_WIDTH_P-1:0]              araddr,
    input  logic [7:0]                                arlen,
    input  logic                                      arvalid,
    output logic                                      arready,
    output logic [AXI4_ID_WIDTH_P-1:0]                rid,
    output logic [AXI4_DATA_WIDTH_P-1:0]              rdata,
    output logic [1:0]                                rresp,
    output logic                                      rlast,
    output logic                                      rvalid,
    input  logic                                      rready,
    output logic [NR_OF_REGS_P*AXI4_DATA_WIDTH_P-1:0] reg_out
);

    localparam int LSB_W = $clog2(AXI4_STRB_WIDTH_P);
    localparam int IDX_W = AXI4_ADDR_WIDTH_P - LSB_W;
    localparam int W     = AXI4_DATA_WIDTH_P;

`ifdef AXI4_REG_SLAVE_DECERR_EN
    localparam logic [1:0] ERR_RESP = 2'b11;
`else
    localparam logic [1:0] ERR_RESP = 2'b10;
`endif
    localparam logic [1:0] OKAY_RESP = 2'b00;

    typedef enum logic { WR_IDLE, WR_RESP } wr_state_t;
    typedef enum logic { RD_IDLE, RD_DATA } rd_state_t;

    // write channel state
    wr_state_t                  wr_state_q, wr_state_d;
    logic                       aw_got_q, aw_got_d;
    logic [IDX_W-1:0]           aw_idx_q, aw_idx_d;
    logic                       w_got_q, w_got_d;
    logic [W-1:0]               wdata_q, wdata_d;
    logic [AXI4_STRB_WIDTH_P-1:0] wstrb_q, wstrb_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic [W-1:0]               regs_q [NR_OF_REGS_P];
    logic [W-1:0]               regs_d [NR_OF_REGS_P];

    // read channel state
    rd_state_t                  rd_state_q, rd_state_d;
    logic [IDX_W-1:0]           rd_idx_q, rd_idx_d;
    logic [7:0]                 rd_cnt_q, rd_cnt_d;
    logic [W-1:0]               rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic                       rlast_q, rlast_d;

    // combinational helpers for the write commit
    logic                       have_aw, have_w;
    logic [IDX_W-1:0]           w_idx;
    logic [W-1:0]               w_data;
    logic [AXI4_STRB_WIDTH_P-1:0] w_strb;
    logic                       rd_load;

    // wlast is assumed 1 and low address bits are ignored by design
    logic unused_inputs;
    assign unused_inputs = ^{wlast, awaddr, araddr};

    assign awready = (wr_state_q == WR_IDLE) && !aw_got_q;
    assign wready  = (wr_state_q == WR_IDLE) && !w_got_q;
    assign bvalid  = (wr_state_q == WR_RESP);
    assign bresp   = bresp_q;
    assign arready = (rd_state_q == RD_IDLE);
    assign rvalid  = (rd_state_q == RD_DATA);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = AXI4_ID_WIDTH_P'(RID_VALUE_P);

    for (genvar g = 0; g < NR_OF_REGS_P; g++) begin : g_flat
        assign reg_out[g*W +: W] = regs_q[g];
    end

    // Write FSM next state: capture AW/W independently, commit once both are present
    always_comb begin
        wr_state_d = wr_state_q;
        aw_got_d   = aw_got_q;
        aw_idx_d   = aw_idx_q;
        w_got_d    = w_got_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        have_aw    = aw_got_q || awvalid;
        have_w     = w_got_q || wvalid;
        w_idx      = aw_got_q ? aw_idx_q : awaddr[AXI4_ADDR_WIDTH_P-1:LSB_W];
        w_data     = w_got_q ? wdata_q : wdata;
        w_strb     = w_got_q ? wstrb_q : wstrb;
        case (wr_state_q)
            WR_IDLE: begin
                if (have_aw && have_w) begin
                    aw_got_d   = 1'b0;
                    w_got_d    = 1'b0;
                    wr_state_d = WR_RESP;
                    bresp_d    = (w_idx < IDX_W'(NR_OF_REGS_P)) ? OKAY_RESP : ERR_RESP;
                    for (int unsigned k = 0; k < NR_OF_REGS_P; k++) begin
                        if (w_idx == IDX_W'(k)) begin
                            for (int unsigned i = 0; i < AXI4_STRB_WIDTH_P; i++) begin
                                if (w_strb[i]) regs_d[k][8*i +: 8] = w_data[8*i +: 8];
                            end
                        end
                    end
                end else begin
                    if (!aw_got_q && awvalid) begin
                        aw_got_d = 1'b1;
                        aw_idx_d = awaddr[AXI4_ADDR_WIDTH_P-1:LSB_W];
                    end
                    if (!w_got_q && wvalid) begin
                        w_got_d = 1'b1;
                        wdata_d = wdata;
                        wstrb_d = wstrb;
                    end
                end
            end
            WR_RESP: begin
                if (bready) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Read FSM next state: load each beat one cycle ahead of its presentation
    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_cnt_d   = rd_cnt_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        rd_load    = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (arvalid) begin
                    rd_idx_d   = araddr[AXI4_ADDR_WIDTH_P-1:LSB_W];
                    rd_cnt_d   = arlen;
                    rlast_d    = (arlen == 8'd0);
                    rd_load    = 1'b1;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        rlast_d    = 1'b0;
                        rd_state_d = RD_IDLE;
                    end else begin
                        // index saturates rather than wrapping past the top of the space
                        rd_idx_d = (rd_idx_q == '1) ? rd_idx_q : rd_idx_q + IDX_W'(1);
                        rd_cnt_d = rd_cnt_q - 8'd1;
                        rlast_d  = (rd_cnt_q == 8'd1);
                        rd_load  = 1'b1;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
        // beats read the pre-commit register values, so a colliding write is seen one beat later
        if (rd_load) begin
            rdata_d = '0;
            rresp_d = (rd_idx_d < IDX_W'(NR_OF_REGS_P)) ? OKAY_RESP : ERR_RESP;
            for (int unsigned k = 0; k < NR_OF_REGS_P; k++) begin
                if (rd_idx_d == IDX_W'(k)) rdata_d = regs_q[k];
            end
        end
    end

    // Write channel and register bank state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= WR_IDLE;
            aw_got_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_got_q    <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= OKAY_RESP;
            for (int unsigned k = 0; k < NR_OF_REGS_P; k++) regs_q[k] <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_got_q   <= aw_got_d;
            aw_idx_q   <= aw_idx_d;
            w_got_q    <= w_got_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
        end
    end

    // Read channel state
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            rd_idx_q   <= '0;
            rd_cnt_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= OKAY_RESP;
            rlast_q    <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_cnt_q   <= rd_cnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

endmodule

// File: tb/tb_axi4_reg_slave.sv
// Directed testbench for axi4_reg_slave with default parameters.
module tb_axi4_reg_slave;

`ifdef AXI4_REG_SLAVE_DECERR_EN
    localparam logic [1:0] EXP_ERR = 2'b11;
`else
    localparam logic [1:0] EXP_ERR = 2'b10;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [15:0]  araddr;
    logic [7:0]   arlen;
    logic         arvalid;
    logic         arready;
    logic [1:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [255:0] reg_out;

    int tests = 0;
    int fails = 0;

    axi4_reg_slave #(
        .AXI4_ID_WIDTH_P(2), .AXI4_ADDR_WIDTH_P(16), .AXI4_DATA_WIDTH_P(32),
        .AXI4_STRB_WIDTH_P(4), .NR_OF_REGS_P(8), .RID_VALUE_P(0)
    ) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .reg_out(reg_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d);
        awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tick;
        bready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wlast = 1'b1;
        wvalid = 0; bready = 0; araddr = '0; arlen = '0; arvalid = 0; rready = 0;
        tick; tick;
        tests++; if ({awready, wready, arready} !== 3'b111) begin fails++; $display("FAIL reset_ready: got %b expected 111", {awready, wready, arready}); end
        tests++; if ({bvalid, rvalid, rlast} !== 3'b000) begin fails++; $display("FAIL reset_valid: got %b expected 000", {bvalid, rvalid, rlast}); end
        tests++; if ({bresp, rresp} !== 4'b0000) begin fails++; $display("FAIL reset_resp: got %b expected 0000", {bresp, rresp}); end
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        tests++; if (reg_out !== 256'h0) begin fails++; $display("FAIL reset_regs: got %h expected 0", reg_out); end
        tests++; if (rid !== 2'd0) begin fails++; $display("FAIL reset_rid: got %0d expected 0", rid); end
        rst = 1'b0;
    endtask

    task automatic test_same_cycle_write;
        awaddr = 16'h0008; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick;
        awvalid = 0; wvalid = 0;
        tests++; if (reg_out[95:64] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr1_reg2: got %h expected deadbeef", reg_out[95:64]); end
        tests++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin fails++; $display("FAIL wr1_b: got bvalid=%b bresp=%b expected 1/00", bvalid, bresp); end
        tests++; if (awready !== 1'b0) begin fails++; $display("FAIL wr1_awready: got %b expected 0", awready); end
        bready = 1;
        tick;
        bready = 0;
        tests++; if ({bvalid, awready, wready} !== 3'b011) begin fails++; $display("FAIL wr1_done: got %b expected 011", {bvalid, awready, wready}); end
    endtask

    task automatic test_w_before_aw;
        rst = 1; tick; rst = 0;
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
        tick;
        wvalid = 0;
        tests++; if ({wready, awready, bvalid} !== 3'b010) begin fails++; $display("FAIL wfirst_capture: got %b expected 010", {wready, awready, bvalid}); end
        tick;
        awaddr = 16'h0004; awvalid = 1;
        tick;
        awvalid = 0;
        tests++; if (reg_out[63:32] !== 32'h00220044) begin fails++; $display("FAIL wfirst_reg1: got %h expected 00220044", reg_out[63:32]); end
        tests++; if (bvalid !== 1'b1) begin fails++; $display("FAIL wfirst_bvalid: got %b expected 1", bvalid); end
        for (int i = 0; i < 3; i++) begin
            tick;
            tests++; if ({bvalid, awready, wready} !== 3'b100) begin fails++; $display("FAIL wfirst_hold%0d: got %b expected 100", i, {bvalid, awready, wready}); end
        end
        bready = 1;
        tick;
        bready = 0;
        tests++; if ({bvalid, awready, wready} !== 3'b011) begin fails++; $display("FAIL wfirst_done: got %b expected 011", {bvalid, awready, wready}); end
    endtask

    task automatic test_read_burst;
        for (int i = 0; i < 4; i++) do_write(16'(i * 4), 32'hA0 + 32'(i));
        araddr = 16'h0000; arlen = 8'd3; arvalid = 1; rready = 1;
        tick;
        arvalid = 0;
        tests++; if (arready !== 1'b0) begin fails++; $display("FAIL burst_arready: got %b expected 0", arready); end
        for (int b = 0; b < 4; b++) begin
            tests++;
            if (rvalid !== 1'b1 || rdata !== 32'hA0 + 32'(b) || rlast !== (b == 3) || rresp !== 2'b00) begin
                fails++; $display("FAIL burst_beat%0d: got v=%b d=%h l=%b r=%b expected 1/%h/%b/00", b, rvalid, rdata, rlast, rresp, 32'hA0 + 32'(b), (b == 3));
            end
            tick;
        end
        rready = 0;
        tests++; if ({rvalid, arready} !== 2'b01) begin fails++; $display("FAIL burst_end: got %b expected 01", {rvalid, arready}); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] exp_d [4];
        logic [1:0]  exp_r [4];
        do_write(16'h0018, 32'h66);
        do_write(16'h001C, 32'h77);
        awaddr = 16'h0020; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick;
        awvalid = 0; wvalid = 0;
        tests++; if (bvalid !== 1'b1 || bresp !== EXP_ERR) begin fails++; $display("FAIL oor_wresp: got v=%b r=%b expected 1/%b", bvalid, bresp, EXP_ERR); end
        bready = 1; tick; bready = 0;
        tests++;
        if (reg_out !== {32'h77, 32'h66, 32'h0, 32'h0, 32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
            fails++; $display("FAIL oor_regs: got %h expected 77,66,0,0,a3..a0", reg_out);
        end
        exp_d = '{32'h66, 32'h77, 32'h0, 32'h0};
        exp_r = '{2'b00, 2'b00, EXP_ERR, EXP_ERR};
        araddr = 16'h0018; arlen = 8'd3; arvalid = 1; rready = 1;
        tick;
        arvalid = 0;
        for (int b = 0; b < 4; b++) begin
            tests++;
            if (rvalid !== 1'b1 || rdata !== exp_d[b] || rresp !== exp_r[b] || rlast !== (b == 3)) begin
                fails++; $display("FAIL oor_beat%0d: got d=%h r=%b l=%b expected %h/%b/%b", b, rdata, rresp, rlast, exp_d[b], exp_r[b], (b == 3));
            end
            tick;
        end
        rready = 0;
    endtask

    task automatic test_stall;
        logic [31:0] exp_d [8];
        int hs;
        int cyc;
        logic r;
        exp_d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h0, 32'h66, 32'h77};
        hs = 0; cyc = 0;
        araddr = 16'h0000; arlen = 8'd7; arvalid = 1; rready = 0;
        tick;
        arvalid = 0;
        while (hs < 8 && cyc < 200) begin
            r = 1'($urandom_range(0, 1));
            rready = r;
            if (r) begin
                tests++;
                if (rvalid !== 1'b1 || rdata !== exp_d[hs] || rlast !== (hs == 7)) begin
                    fails++; $display("FAIL stall_hs%0d: got v=%b d=%h l=%b expected 1/%h/%b", hs, rvalid, rdata, rlast, exp_d[hs], (hs == 7));
                end
                hs++;
            end
            tick;
            cyc++;
            if (!r) begin
                tests++;
                if (rvalid !== 1'b1 || rdata !== exp_d[hs] || rlast !== (hs == 7)) begin
                    fails++; $display("FAIL stall_hold%0d: got v=%b d=%h l=%b expected 1/%h/%b", hs, rvalid, rdata, rlast, exp_d[hs], (hs == 7));
                end
            end
        end
        rready = 0;
        tests++; if (hs != 8) begin fails++; $display("FAIL stall_count: got %0d handshakes expected 8", hs); end
        tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL stall_end: got rvalid=%b expected 0", rvalid); end
    endtask

    task automatic test_rw_collision;
        araddr = 16'h0000; arlen = 8'd0; arvalid = 1; rready = 0;
        awaddr = 16'h0000; wdata = 32'hB0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick;
        arvalid = 0; awvalid = 0; wvalid = 0;
        tests++; if (rdata !== 32'hA0 || rlast !== 1'b1) begin fails++; $display("FAIL coll_old: got d=%h l=%b expected a0/1", rdata, rlast); end
        tests++; if (reg_out[31:0] !== 32'hB0) begin fails++; $display("FAIL coll_reg0: got %h expected b0", reg_out[31:0]); end
        rready = 1; bready = 1;
        tick;
        rready = 0; bready = 0;
        arvalid = 1;
        tick;
        arvalid = 0;
        tests++; if (rvalid !== 1'b1 || rdata !== 32'hB0) begin fails++; $display("FAIL coll_new: got v=%b d=%h expected 1/b0", rvalid, rdata); end
        rready = 1; tick; rready = 0;
    endtask

    task automatic test_reset_midflight;
        awaddr = 16'h000C; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick;
        awvalid = 0; wvalid = 0;
        araddr = 16'h0000; arlen = 8'd7; arvalid = 1; rready = 1;
        tick;
        arvalid = 0;
        tick; tick;
        tests++; if (rdata !== 32'hA2 || bvalid !== 1'b1) begin fails++; $display("FAIL mid_pre: got d=%h b=%b expected a2/1", rdata, bvalid); end
        rst = 1;
        awaddr = 16'h0000; wdata = 32'hFFFFFFFF; awvalid = 1; wvalid = 1;
        tick;
        rst = 0; awvalid = 0; wvalid = 0; rready = 0;
        tests++; if ({rvalid, bvalid, rlast} !== 3'b000) begin fails++; $display("FAIL mid_valid: got %b expected 000", {rvalid, bvalid, rlast}); end
        tests++; if ({awready, wready, arready} !== 3'b111) begin fails++; $display("FAIL mid_ready: got %b expected 111", {awready, wready, arready}); end
        tests++; if (reg_out !== 256'h0 || rdata !== 32'h0) begin fails++; $display("FAIL mid_regs: got regs=%h rdata=%h expected 0", reg_out, rdata); end
    endtask

    initial begin
        test_reset;
        test_same_cycle_write;
        test_w_before_aw;
        test_read_burst;
        test_out_of_range;
        test_stall;
        test_rw_collision;
        test_reset_midflight;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
